// File: rtl/axil_dpp_counter_bank_pkg.sv
// dpp_counter_pkg: shared definitions for the DPP event counter bank.
//   - byte offsets of the AXI4-Lite register map
//   - CTRL / STATUS bit positions
//   - status_t, the layout of the STATUS word (up to 8 channel overflow bits)
package dpp_counter_pkg;

    localparam logic [31:0] REG_CTRL       = 32'h00;
    localparam logic [31:0] REG_STATUS     = 32'h04;
    localparam logic [31:0] REG_LIVE_SNAP  = 32'h08;
    localparam logic [31:0] REG_LLD        = 32'h0C;
    localparam logic [31:0] REG_ULD        = 32'h10;
    localparam logic [31:0] REG_COUNT_BASE = 32'h20;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_CLEAR      = 1;
    localparam int CTRL_SNAP       = 2;
    localparam int STATUS_LIVE_OVF = 31;
    localparam int MAX_CH          = 8;

    typedef struct packed {
        logic              live_ovf;
        logic [22:0]       reserved;
        logic [MAX_CH-1:0] ch_ovf;
    } status_t;

endpackage

// File: rtl/axil_dpp_counter_bank_if.sv
// axil_dpp_counter_bank_if: AXI4-Lite bus bundle.
//   master modport: drives aw*/w*/ar* valids and payload, bready, rready
//   slave modport : drives awready, wready, b*, arready, r*
interface axil_dpp_counter_bank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_dpp_counter_bank_chan.sv
// dpp_chan_counter: one event channel of the counter bank.
//   Optional feature macro: DPP_ENERGY_WINDOW_EN (energy window qualification).
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : CTRL.ENABLE
//   clear, snap       : one-cycle CTRL pulses (write-accept edge)
//   ovf_clr           : W1C of this channel's STATUS bit
//   evt_valid         : one-cycle event pulse
//   evt_energy        : peak amplitude of the event
//   lld, uld          : energy window bounds (unused without the macro)
//   count_snap        : snapshot of the live count
//   ovf               : sticky overflow flag
module dpp_chan_counter #(
    parameter int CNT_W = 32,
    parameter int EN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             snap,
    input  logic             ovf_clr,
    input  logic             evt_valid,
    input  logic [EN_W-1:0]  evt_energy,
    input  logic [EN_W-1:0]  lld,
    input  logic [EN_W-1:0]  uld,
    output logic [CNT_W-1:0] count_snap,
    output logic             ovf
);
    import dpp_counter_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_live;
    logic             qualified;
    logic             hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

`ifdef DPP_ENERGY_WINDOW_EN
    // An inverted window (lld > uld) can never be satisfied, so it rejects all.
    assign qualified = (evt_energy >= lld) && (evt_energy <= uld);
`else
    logic unused_energy;
    assign unused_energy = ^{evt_energy, lld, uld};
    assign qualified     = 1'b1;
`endif

    // Events coinciding with CLEAR are dropped.
    assign hit = enable && evt_valid && qualified && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_live <= '0;
            count_snap <= '0;
            ovf        <= 1'b0;
        end else begin
            // Snapshot reads the pre-update value, so SNAP|CLEAR captures pre-clear.
            if (snap) count_snap <= count_live;
            if (clear) count_live <= '0;
            else if (hit) count_live <= sat_inc(count_live);
            // A new overflow wins over a simultaneous W1C so it is never lost.
            if (hit && (count_live == CNT_MAX)) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end
endmodule

// File: rtl/axil_dpp_counter_bank.sv
// axil_dpp_counter_bank: AXI4-Lite multi-channel event counter with live time,
// atomic snapshot/clear and optional energy window.
//   Optional feature macro: DPP_ENERGY_WINDOW_EN (LLD/ULD energy window).
//   s00_axi_aclk    : single clock for bus and event logic
//   s00_axi_aresetn : asynchronous active-low reset
//   evt_valid       : per-channel event pulses
//   evt_energy      : per-channel energies, channel i at [i*EN_W +: EN_W]
//   s00_axi         : AXI4-Lite slave
//   irq_ovf         : high while any STATUS overflow bit is set
module axil_dpp_counter_bank #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 32,
    parameter int EN_W               = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    input  logic [NUM_CH-1:0]        evt_valid,
    input  logic [NUM_CH*EN_W-1:0]   evt_energy,
    axil_dpp_counter_bank_if.slave   s00_axi,
    output logic                     irq_ovf
);
    import dpp_counter_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_RESP} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [31:0] aw_addr32, ar_addr32, aw_off, ar_off;
    logic        wr_fire, ctrl_wr, status_wr, clear_pulse, snap_pulse, live_ovf_clr;
    logic [NUM_CH-1:0] ch_ovf_clr, ch_ovf;
    logic              ctrl_enable, live_ovf;
    logic [CNT_W-1:0]  live_time, live_snap;
    logic [CNT_W-1:0]  count_snap [NUM_CH];
    logic [EN_W-1:0]   lld, uld;
    logic [31:0]       lld_rd, uld_rd;
    status_t           status_word;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic              unused_bus;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign aw_addr32 = 32'(s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:0]);
    assign ar_addr32 = 32'(s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:0]);
    assign aw_off    = {aw_addr32[31:2], 2'b00};
    assign ar_off    = {ar_addr32[31:2], 2'b00};
    assign unused_bus = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.wstrb, s00_axi.wdata,
                          aw_addr32[1:0], ar_addr32[1:0]};

    // Register writes land on the edge where awready/wready are sampled high.
    assign wr_fire      = s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid;
    assign ctrl_wr      = wr_fire && (aw_off == REG_CTRL) && s00_axi.wstrb[0];
    assign status_wr    = wr_fire && (aw_off == REG_STATUS) && s00_axi.wstrb[0];
    assign clear_pulse  = ctrl_wr && s00_axi.wdata[CTRL_CLEAR];
    assign snap_pulse   = ctrl_wr && s00_axi.wdata[CTRL_SNAP];
    assign live_ovf_clr = status_wr && s00_axi.wdata[STATUS_LIVE_OVF];
    assign ch_ovf_clr   = status_wr ? s00_axi.wdata[NUM_CH-1:0] : '0;

    assign s00_axi.bresp = 2'b00;
    assign s00_axi.rresp = 2'b00;
    assign irq_ovf       = (|ch_ovf) || live_ovf;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_enable <= 1'b0;
            live_time   <= '0;
            live_snap   <= '0;
            live_ovf    <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_enable <= s00_axi.wdata[CTRL_ENABLE];
            if (snap_pulse) live_snap <= live_time;
            if (clear_pulse) live_time <= '0;
            else if (ctrl_enable) live_time <= sat_inc(live_time);
            if (ctrl_enable && !clear_pulse && (live_time == CNT_MAX)) live_ovf <= 1'b1;
            else if (live_ovf_clr) live_ovf <= 1'b0;
        end
    end

`ifdef DPP_ENERGY_WINDOW_EN
    function automatic logic [EN_W-1:0] apply_strb(input logic [EN_W-1:0] old,
                                                   input logic [31:0] data,
                                                   input logic [3:0] strb);
        logic [31:0] merged;
        merged = 32'(old);
        for (int b = 0; b < 4; b++)
            if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
        return merged[EN_W-1:0];
    endfunction

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            lld <= '0;
            uld <= '1;
        end else if (wr_fire) begin
            if (aw_off == REG_LLD) lld <= apply_strb(lld, s00_axi.wdata, s00_axi.wstrb);
            if (aw_off == REG_ULD) uld <= apply_strb(uld, s00_axi.wdata, s00_axi.wstrb);
        end
    end
    assign lld_rd = 32'(lld);
    assign uld_rd = 32'(uld);
`else
    assign lld    = '0;
    assign uld    = '1;
    assign lld_rd = '0;
    assign uld_rd = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        dpp_chan_counter #(.CNT_W(CNT_W), .EN_W(EN_W)) u_chan (
            .clk        (s00_axi_aclk),
            .rst_n      (s00_axi_aresetn),
            .enable     (ctrl_enable),
            .clear      (clear_pulse),
            .snap       (snap_pulse),
            .ovf_clr    (ch_ovf_clr[g]),
            .evt_valid  (evt_valid[g]),
            .evt_energy (evt_energy[g*EN_W +: EN_W]),
            .lld        (lld),
            .uld        (uld),
            .count_snap (count_snap[g]),
            .ovf        (ch_ovf[g])
        );
    end

    always_comb begin
        status_word = '0;
        status_word.ch_ovf[NUM_CH-1:0] = ch_ovf;
        status_word.live_ovf = live_ovf;
    end

    always_comb begin
        rd_word = '0;
        case (ar_off)
            REG_CTRL:      rd_word[CTRL_ENABLE] = ctrl_enable;
            REG_STATUS:    rd_word = status_word;
            REG_LIVE_SNAP: rd_word = 32'(live_snap);
            REG_LLD:       rd_word = lld_rd;
            REG_ULD:       rd_word = uld_rd;
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (ar_off == REG_COUNT_BASE + 32'(4 * i)) rd_word = 32'(count_snap[i]);
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_state        <= WR_IDLE;
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (s00_axi.awvalid && s00_axi.wvalid) begin
                    s00_axi.awready <= 1'b1;
                    s00_axi.wready  <= 1'b1;
                    wr_state        <= WR_ACK;
                end
                WR_ACK: begin
                    s00_axi.awready <= 1'b0;
                    s00_axi.wready  <= 1'b0;
                    s00_axi.bvalid  <= 1'b1;
                    wr_state        <= WR_RESP;
                end
                WR_RESP: if (s00_axi.bready) begin
                    s00_axi.bvalid <= 1'b0;
                    wr_state       <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rd_state        <= RD_IDLE;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: if (s00_axi.arvalid) begin
                    s00_axi.arready <= 1'b1;
                    rd_state        <= RD_ACK;
                end
                RD_ACK: begin
                    s00_axi.arready <= 1'b0;
                    s00_axi.rvalid  <= 1'b1;
                    s00_axi.rdata   <= rd_word;
                    rd_state        <= RD_RESP;
                end
                RD_RESP: if (s00_axi.rready) begin
                    s00_axi.rvalid <= 1'b0;
                    rd_state       <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_dpp_counter_bank.sv
// tb_axil_dpp_counter_bank: scoreboard bench for axil_dpp_counter_bank
// (NUM_CH=4, CNT_W=8, EN_W=16). Expected values follow DPP_ENERGY_WINDOW_EN.
module tb_axil_dpp_counter_bank;
`ifdef DPP_ENERGY_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int EN_W   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_CH-1:0]      evt_valid = '0;
    logic [NUM_CH*EN_W-1:0] evt_energy = {NUM_CH{16'd150}};
    logic irq_ovf;

    axil_dpp_counter_bank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    axil_dpp_counter_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EN_W(EN_W),
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .evt_valid(evt_valid), .evt_energy(evt_energy),
        .s00_axi(bus), .irq_ovf(irq_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] exp_r[$];
    string       name_r[$];
    logic [1:0]  exp_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: handshakes complete on the next posedge; observe them at negedge.
    always @(negedge clk) begin
        if (bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: bresp=%0d with no write pending", bus.bresp);
            end else check("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
        end
        if (bus.rvalid && bus.rready) begin
            if (exp_r.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: rdata=0x%08h with no read pending", bus.rdata);
            end else begin
                check(name_r.pop_front(), bus.rdata, exp_r.pop_front());
                check("rresp", 32'(bus.rresp), 32'd0);
            end
        end
    end

    task automatic wait_awready();
        int n = 0;
        while (bus.awready !== 1'b1) begin
            @(posedge clk); #1;
            if (++n > 40) begin timeout("awready"); return; end
        end
    endtask

    task automatic wait_arready();
        int n = 0;
        while (bus.arready !== 1'b1) begin
            @(posedge clk); #1;
            if (++n > 40) begin timeout("arready"); return; end
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (exp_b.size() != 0) begin
            @(posedge clk); #1;
            if (++n > 40) begin timeout("bvalid"); exp_b.delete(); return; end
        end
    endtask

    task automatic wait_r();
        int n = 0;
        while (exp_r.size() != 0) begin
            @(posedge clk); #1;
            if (++n > 40) begin timeout("rvalid"); exp_r.delete(); name_r.delete(); return; end
        end
    endtask

    // acc_cyc: cycle stamp of the write-accept edge; evt_acc pulses events on that edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [NUM_CH-1:0] evt_acc, output int acc_cyc);
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b.push_back(2'b00);
        wait_awready();
        evt_valid = evt_acc;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        evt_valid = '0;
        wait_b();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int unused_c;
        axi_write(a, d, 4'hF, '0, unused_c);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1;
        exp_r.push_back(exp);
        name_r.push_back(name);
        wait_arready();
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        wait_r();
    endtask

    task automatic pulse(input int ch, input logic [15:0] e);
        @(negedge clk);
        evt_valid[ch] = 1'b1;
        evt_energy[ch*EN_W +: EN_W] = e;
        @(negedge clk);
        evt_valid = '0;
    endtask

    initial begin
        int e1, e2, eb, ec, n;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset state
        #12;
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_irq", 32'(irq_ovf), 0);
        @(negedge clk); rst_n = 1'b1;
        axi_read(6'h00, 32'h0, "rst_ctrl");
        axi_read(6'h04, 32'h0, "rst_status");
        axi_read(6'h08, 32'h0, "rst_live");
        axi_read(6'h0C, 32'h0, "rst_lld");
        axi_read(6'h10, WIN ? 32'h0000FFFF : 32'h0, "rst_uld");
        for (int i = 0; i < NUM_CH; i++) axi_read(6'(8 + i) << 2, 32'h0, "rst_count");
        axi_read(6'h14, 32'h0, "unmapped_14");
        axi_read(6'h30, 32'h0, "unmapped_ch4");

        // Basic counting and live time
        axi_write(6'h00, 32'h3, 4'hF, '0, e1);
        for (int i = 0; i < 5; i++) begin
            pulse(0, 16'd150);
            if (i < 3) pulse(2, 16'd150);
        end
        axi_write(6'h00, 32'h0, 4'hF, '0, e2);
        wr(6'h00, 32'h4);
        axi_read(6'h20, 32'd5, "cnt_ch0");
        axi_read(6'h24, 32'd0, "cnt_ch1");
        axi_read(6'h28, 32'd3, "cnt_ch2");
        axi_read(6'h2C, 32'd0, "cnt_ch3");
        axi_read(6'h08, 32'(e2 - e1), "live_enabled_cycles");
        axi_read(6'h00, 32'h0, "ctrl_pulses_read0");

        // Energy window
        wr(6'h0C, 32'd100);
        wr(6'h10, 32'd200);
        axi_read(6'h0C, WIN ? 32'd100 : 32'd0, "lld_rb");
        axi_read(6'h10, WIN ? 32'd200 : 32'd0, "uld_rb");
        wr(6'h00, 32'h3);
        pulse(1, 16'd99);
        pulse(1, 16'd100);
        pulse(1, 16'd200);
        pulse(1, 16'd201);
        wr(6'h00, 32'h4);
        axi_read(6'h24, WIN ? 32'd2 : 32'd4, "window_ch1");
        axi_read(6'h20, 32'd0, "window_ch0_cleared");
        begin
            int unused_c;
            axi_write(6'h10, 32'h0000_12AB, 4'b0001, '0, unused_c);
        end
        axi_read(6'h10, WIN ? 32'h0000_00AB : 32'd0, "uld_strb_byte0");

        // Saturation and overflow with CNT_W=8
        wr(6'h00, 32'h3);
        @(negedge clk); evt_valid[3] = 1'b1;
        repeat (256) @(posedge clk);
        @(negedge clk); evt_valid = '0;
        wr(6'h00, 32'h4);
        axi_read(6'h2C, 32'd255, "sat_ch3");
        axi_read(6'h28, 32'd0, "sat_ch2_zero");
        axi_read(6'h08, 32'd255, "sat_live");
        axi_read(6'h04, 32'h8000_0008, "status_ovf");
        check("irq_set", 32'(irq_ovf), 1);
        begin
            int unused_c;
            axi_write(6'h04, 32'h8, 4'b0010, '0, unused_c);
        end
        axi_read(6'h04, 32'h8000_0008, "status_strb_ignored");
        wr(6'h04, 32'h8);
        axi_read(6'h04, 32'h8000_0000, "status_w1c_ch3");
        check("irq_live_only", 32'(irq_ovf), 1);
        wr(6'h04, 32'h8000_0000);
        axi_read(6'h04, 32'h0, "status_w1c_live");
        check("irq_clear", 32'(irq_ovf), 0);

        // SNAP|CLEAR together with a ch0 event
        wr(6'h00, 32'h3);
        for (int i = 0; i < 3; i++) pulse(0, 16'd150);
        axi_write(6'h00, 32'h7, 4'hF, 4'b0001, eb);
        axi_write(6'h00, 32'h4, 4'hF, '0, ec);
        axi_read(6'h20, 32'd0, "post_clear_snap_ch0");
        axi_read(6'h08, 32'(ec - eb - 1), "live_snap_while_enabled");
        wr(6'h00, 32'h3);
        axi_write(6'h00, 32'h7, 4'hF, 4'b0001, eb);
        axi_read(6'h20, 32'd0, "clear_drops_evt");
        wr(6'h00, 32'h1);
        for (int i = 0; i < 3; i++) pulse(0, 16'd150);
        axi_write(6'h00, 32'h7, 4'hF, 4'b0001, eb);
        axi_read(6'h20, 32'd3, "snapclear_pre_count");
        wr(6'h00, 32'h4);
        axi_read(6'h20, 32'd0, "snap_after_clear");

        // Backpressure on B with a second write pending
        bus.bready = 1'b0;
        @(negedge clk);
        bus.awaddr = 6'h0C; bus.wdata = 32'd5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b.push_back(2'b00);
        wait_awready();
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        bus.wdata = 32'd7;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b.push_back(2'b00);
        repeat (10) begin
            @(posedge clk); #1;
            check("awready_held_low", 32'(bus.awready), 0);
            check("bvalid_held", 32'(bus.bvalid), 1);
        end
        bus.bready = 1'b1;
        wait_awready();
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_b();
        axi_read(6'h0C, WIN ? 32'd7 : 32'd0, "lld_second_write");

        // Reset during an outstanding read
        bus.rready = 1'b0;
        @(negedge clk);
        bus.araddr = 6'h00; bus.arvalid = 1'b1;
        exp_r.push_back(32'h0);
        name_r.push_back("lost_read");
        wait_arready();
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check("rvalid_before_reset", 32'(bus.rvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rvalid_async_reset", 32'(bus.rvalid), 0);
        check("arready_async_reset", 32'(bus.arready), 0);
        exp_r.delete();
        name_r.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rready = 1'b1;
        axi_read(6'h00, 32'h0, "post_rst_ctrl");
        axi_read(6'h20, 32'h0, "post_rst_count");
        axi_read(6'h10, WIN ? 32'h0000FFFF : 32'h0, "post_rst_uld");

        check("queues_drained", 32'(exp_r.size() + exp_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
